// File: rtl/game_round_ctl_pkg.sv
// -----------------------------------------------------------------------------
// game_round_ctl_pkg
// Shared game definitions: round state encoding, score width and saturation
// helper, default round timing constants, and the VGA bus bundle used by the
// display side of the game.
// -----------------------------------------------------------------------------
package game_round_ctl_pkg;

    // Round controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } round_state_t;

    // Score width and saturation ceiling
    localparam int SCORE_W = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Default round timing
    localparam int DEF_ROUND_SECONDS  = 60;
    localparam int DEF_FRAMES_PER_SEC = 60;
    localparam int DEF_HOLD_FRAMES    = 120;

    // VGA bus bundle (4 bits per colour channel)
    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } vga_bus_t;

    // Add one to a score, sticking at the ceiling instead of wrapping
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/game_round_ctl_edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// 1-bit rising-edge detector. One flop remembers the previous input value;
// rise is high for the single cycle where d is 1 and the stored value is 0.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (clears the history flop)
//   d      in  level input, synchronous to clk
//   rise   out one-cycle pulse on a 0->1 transition of d
// -----------------------------------------------------------------------------
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/game_round_ctl.sv
// -----------------------------------------------------------------------------
// game_round_ctl
// Timed game round controller: IDLE -> RUN on start, counts frames from the
// VGA vsync into seconds, accumulates saturating player scores during the
// round, then shows a game-over screen (OVER) for at least HOLD_FRAMES frames
// before a new start is accepted. All outputs are registered.
// Ports:
//   pclk          in   pixel clock, sole clock
//   rst_n         in   asynchronous active-low reset
//   vsync_in      in   VGA vsync, rising edge = one frame tick
//   start_btn     in   start request (level, synchronised)
//   players_sel   in   0 = one player, 1 = two players
//   p1_hit        in   player-1 scoring event (level)
//   p2_hit        in   player-2 scoring event (level)
//   time_out      out  1 while the game-over screen is shown
//   no_of_players out  players_sel latched at round start
//   player1_score out  player-1 score (saturating)
//   player2_score out  player-2 score (saturating)
//   seconds_left  out  remaining round seconds
//   round_active  out  1 while the round runs
// -----------------------------------------------------------------------------
module game_round_ctl
    import game_round_ctl_pkg::*;
#(
    parameter int ROUND_SECONDS  = DEF_ROUND_SECONDS,
    parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
    parameter int HOLD_FRAMES    = DEF_HOLD_FRAMES
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               vsync_in,
    input  logic               start_btn,
    input  logic               players_sel,
    input  logic               p1_hit,
    input  logic               p2_hit,
    output logic               time_out,
    output logic               no_of_players,
    output logic [SCORE_W-1:0] player1_score,
    output logic [SCORE_W-1:0] player2_score,
    output logic [7:0]         seconds_left,
    output logic               round_active
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    round_state_t  state;
    logic [FW-1:0] frame_cnt;
    logic [HW-1:0] hold_cnt;

    logic tick_evt, start_evt, p1_evt, p2_evt;
    logic start_round;

    edge_det u_ed_vsync (.clk(pclk), .rst_n(rst_n), .d(vsync_in),  .rise(tick_evt));
    edge_det u_ed_start (.clk(pclk), .rst_n(rst_n), .d(start_btn), .rise(start_evt));
    edge_det u_ed_p1    (.clk(pclk), .rst_n(rst_n), .d(p1_hit),    .rise(p1_evt));
    edge_det u_ed_p2    (.clk(pclk), .rst_n(rst_n), .d(p2_hit),    .rise(p2_evt));

    // A start is honoured from IDLE, or from OVER once the display hold expired.
    // Start edges during RUN fall through and are ignored.
    assign start_round = start_evt &&
                         ((state == ST_IDLE) ||
                          ((state == ST_OVER) && (hold_cnt == '0)));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            time_out      <= 1'b0;
            round_active  <= 1'b0;
            no_of_players <= 1'b0;
            player1_score <= '0;
            player2_score <= '0;
            seconds_left  <= 8'(ROUND_SECONDS);
            frame_cnt     <= '0;
            hold_cnt      <= '0;
        end else if (start_round) begin
            state         <= ST_RUN;
            time_out      <= 1'b0;
            round_active  <= 1'b1;
            no_of_players <= players_sel;
            player1_score <= '0;
            player2_score <= '0;
            seconds_left  <= 8'(ROUND_SECONDS);
            frame_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // wait for start; hits are ignored here
                end

                ST_RUN: begin
                    // Hits are counted even on the cycle the round expires.
                    if (p1_evt) begin
                        player1_score <= score_inc(player1_score);
                    end
                    if (p2_evt && no_of_players) begin
                        player2_score <= score_inc(player2_score);
                    end

                    if (tick_evt) begin
                        if (frame_cnt == FW'(FRAMES_PER_SEC - 1)) begin
                            frame_cnt <= '0;
                            if (seconds_left < 8'd2) begin
                                // last second gone: clamp at 0 and end the round
                                seconds_left <= 8'd0;
                                state        <= ST_OVER;
                                time_out     <= 1'b1;
                                round_active <= 1'b0;
                                hold_cnt     <= HW'(HOLD_FRAMES);
                            end else begin
                                seconds_left <= seconds_left - 8'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                end

                ST_OVER: begin
                    // Scores and player count stay frozen for the overlay.
                    if (tick_evt && (hold_cnt != '0)) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    time_out     <= 1'b0;
                    round_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctl.sv
// -----------------------------------------------------------------------------
// tb_game_round_ctl
// Bench for game_round_ctl with a 2 s round, 4 frames/s, 3-frame hold.
// A round model tracks ticks elapsed and scores; a compare process checks
// every output each cycle, and directed sequences check literal values.
// -----------------------------------------------------------------------------
module tb_game_round_ctl;

    localparam int RS = 2;
    localparam int FPS = 4;
    localparam int HF = 3;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       vsync_in = 1'b0;
    logic       start_btn = 1'b0;
    logic       players_sel = 1'b0;
    logic       p1_hit = 1'b0;
    logic       p2_hit = 1'b0;
    logic       time_out;
    logic       no_of_players;
    logic [7:0] player1_score;
    logic [7:0] player2_score;
    logic [7:0] seconds_left;
    logic       round_active;

    int checks = 0;
    int errors = 0;
    bit run_checks = 1'b0;

    game_round_ctl #(
        .ROUND_SECONDS (RS),
        .FRAMES_PER_SEC(FPS),
        .HOLD_FRAMES   (HF)
    ) dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .vsync_in     (vsync_in),
        .start_btn    (start_btn),
        .players_sel  (players_sel),
        .p1_hit       (p1_hit),
        .p2_hit       (p2_hit),
        .time_out     (time_out),
        .no_of_players(no_of_players),
        .player1_score(player1_score),
        .player2_score(player2_score),
        .seconds_left (seconds_left),
        .round_active (round_active)
    );

    // ---------------- clock ----------------
    always #5 pclk = ~pclk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- round model ----------------
    // phase: 0 waiting, 1 playing, 2 game over
    int m_phase = 0;
    int m_ticks_run = 0;    // frame ticks since round start
    int m_ticks_over = 0;   // frame ticks since game over (capped at HF)
    int m_p1 = 0, m_p2 = 0, m_np = 0;
    bit pv_vs = 0, pv_st = 0, pv_p1 = 0, pv_p2 = 0;

    always @(posedge pclk or negedge rst_n) begin
        bit ev_v, ev_s, ev_1, ev_2;
        if (!rst_n) begin
            m_phase = 0; m_ticks_run = 0; m_ticks_over = 0;
            m_p1 = 0; m_p2 = 0; m_np = 0;
            pv_vs = 0; pv_st = 0; pv_p1 = 0; pv_p2 = 0;
        end else begin
            ev_v = vsync_in && !pv_vs;
            ev_s = start_btn && !pv_st;
            ev_1 = p1_hit && !pv_p1;
            ev_2 = p2_hit && !pv_p2;
            pv_vs = vsync_in; pv_st = start_btn; pv_p1 = p1_hit; pv_p2 = p2_hit;
            if (ev_s && (m_phase == 0 || (m_phase == 2 && m_ticks_over >= HF))) begin
                m_phase = 1; m_ticks_run = 0; m_p1 = 0; m_p2 = 0; m_np = int'(players_sel);
            end else if (m_phase == 1) begin
                if (ev_1 && m_p1 < 255) m_p1++;
                if (ev_2 && m_np == 1 && m_p2 < 255) m_p2++;
                if (ev_v) begin
                    m_ticks_run++;
                    if (m_ticks_run >= RS * FPS) begin
                        m_phase = 2;
                        m_ticks_over = 0;
                    end
                end
            end else if (m_phase == 2) begin
                if (ev_v && m_ticks_over < HF) m_ticks_over++;
            end
        end
    end

    function automatic int exp_seconds();
        if (m_phase == 1) return RS - m_ticks_run / FPS;
        if (m_phase == 2) return 0;
        return RS;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(posedge pclk) begin
        #1;
        if (run_checks) begin
            check("cyc_round_active",  round_active,  (m_phase == 1) ? 1 : 0);
            check("cyc_time_out",      time_out,      (m_phase == 2) ? 1 : 0);
            check("cyc_seconds_left",  seconds_left,  exp_seconds());
            check("cyc_player1_score", player1_score, m_p1);
            check("cyc_player2_score", player2_score, m_p2);
            check("cyc_no_of_players", no_of_players, m_np);
        end
    end

    // ---------------- drivers ----------------
    // m = {vsync, start, p1, p2}: raise selected inputs for one cycle, then drop
    task automatic pulse(input logic [3:0] m);
        @(negedge pclk);
        vsync_in = m[3]; start_btn = m[2]; p1_hit = m[1]; p2_hit = m[0];
        @(negedge pclk);
        vsync_in = 1'b0; start_btn = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0;
    endtask

    task automatic pulses(input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++) pulse(m);
    endtask

    localparam logic [3:0] VS = 4'b1000, ST = 4'b0100, P1 = 4'b0010, P2 = 4'b0001;

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge pclk);
        check("rst_time_out",     time_out, 0);
        check("rst_round_active", round_active, 0);
        check("rst_seconds_left", seconds_left, 2);
        check("rst_p1_score",     player1_score, 0);
        rst_n = 1'b1;
        run_checks = 1'b1;

        // hits in IDLE are ignored
        pulse(P1);
        check("idle_p1_ignored", player1_score, 0);

        // round 1, two players
        players_sel = 1'b1;
        pulse(ST);
        check("start_round_active", round_active, 1);
        check("start_seconds",      seconds_left, 2);
        check("start_players",      no_of_players, 1);
        check("start_p1_score",     player1_score, 0);
        players_sel = 1'b0;          // must not affect the running round
        pulses(P2, 3);
        pulses(P1, 2);
        check("run_p2_score", player2_score, 3);
        check("run_players_held", no_of_players, 1);
        pulse(ST);                   // ignored in RUN
        check("run_start_ignored", seconds_left, 2);
        pulses(VS, 3);
        check("tick3_seconds", seconds_left, 2);
        pulse(VS);
        check("tick4_seconds", seconds_left, 1);
        pulses(VS, 3);
        check("tick7_time_out", time_out, 0);
        pulse(VS | P1);              // final expiry with a coincident hit
        check("tick8_seconds",  seconds_left, 0);
        check("tick8_time_out", time_out, 1);
        check("tick8_p1_score", player1_score, 3);
        check("tick8_active",   round_active, 0);

        // OVER: hits and early starts ignored
        pulse(P1);
        check("over_p1_ignored", player1_score, 3);
        pulse(ST);
        check("over_start_hold3", time_out, 1);
        pulses(VS, 2);
        pulse(ST);
        check("over_start_hold1", time_out, 1);
        check("over_p2_held", player2_score, 3);
        pulse(VS);
        pulse(ST);
        check("restart_active",  round_active, 1);
        check("restart_seconds", seconds_left, 2);
        check("restart_p1",      player1_score, 0);
        check("restart_players", no_of_players, 0);

        // round 2, one player: saturation and ignored p2
        pulses(P1, 260);
        check("sat_p1_score", player1_score, 255);
        pulses(P2, 5);
        check("oneplayer_p2", player2_score, 0);

        // reset mid-RUN with score 7, 1 second left
        rst_n = 1'b0;
        @(negedge pclk);
        rst_n = 1'b1;
        players_sel = 1'b1;
        pulse(ST);
        pulses(P1, 7);
        pulses(VS, 4);
        check("pre_rst_p1",      player1_score, 7);
        check("pre_rst_seconds", seconds_left, 1);
        @(negedge pclk);
        #3 rst_n = 1'b0;             // between edges: no clock involved
        #1;
        check("async_rst_active",  round_active, 0);
        check("async_rst_p1",      player1_score, 0);
        check("async_rst_seconds", seconds_left, 2);
        check("async_rst_players", no_of_players, 0);
        check("async_rst_timeout", time_out, 0);
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        players_sel = 1'b0;
        pulse(ST);
        check("post_rst_active",  round_active, 1);
        check("post_rst_seconds", seconds_left, 2);
        check("post_rst_players", no_of_players, 0);

        repeat (3) @(negedge pclk);
        run_checks = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_round_ctl.md
GAME_ROUND_CTL -- requirements
Module: game_round_ctl

Interface
REQ-001 SHALL have parameters: ROUND_SECONDS, default 60, round length in seconds; FRAMES_PER_SEC, default 60, frames per second; HOLD_FRAMES, default 120, minimum game-over display time in frames.
REQ-002 SHALL have one clock and asynchronous active-low reset, with ports (clock and reset first):
- pclk  in  1  pixel clock; sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- vsync_in  in  1  VGA vsync; a rising edge is one frame tick.
- start_btn  in  1  start request, level, already synchronised to pclk.
- players_sel  in  1  0 = one player, 1 = two players.
- p1_hit  in  1  player-1 scoring event, level.
- p2_hit  in  1  player-2 scoring event, level.
- time_out  out  1  1 while the game-over screen is shown.
- no_of_players  out  1  players_sel value latched at round start.
- player1_score  out  8  player-1 score.
- player2_score  out  8  player-2 score.
- seconds_left  out  8  remaining round seconds.
- round_active  out  1  1 in state RUN.

Function
REQ-003 SHALL implement the states IDLE, RUN and OVER.
REQ-004 SHALL detect rising edges of vsync_in, start_btn, p1_hit and p2_hit with one registered previous-value flop each; each rising edge SHALL be a one-cycle internal event.
REQ-005 IDLE -> RUN on a start edge; in the same transition: scores <= 0, seconds_left <= ROUND_SECONDS, frame counter <= 0, no_of_players <= players_sel.
REQ-006 In RUN, each frame tick SHALL increment the frame counter; at FRAMES_PER_SEC-1 the counter SHALL wrap to 0 and seconds_left SHALL decrement by 1.
REQ-007 A decrement that makes seconds_left 0 SHALL move the block to OVER on the same clock edge; seconds_left SHALL never wrap below 0.
REQ-008 In RUN, each p1_hit edge SHALL add 1 to player1_score, saturating at 255.
REQ-009 In RUN, each p2_hit edge SHALL add 1 to player2_score, saturating at 255, only when no_of_players = 1; otherwise it SHALL be ignored.
REQ-010 A hit edge in the same cycle as the final second expiry SHALL be counted.
REQ-011 Hit edges in IDLE or OVER SHALL be ignored.
REQ-012 On entry to OVER, a hold counter SHALL load HOLD_FRAMES and decrement on each frame tick, stopping at 0.
REQ-013 In OVER, a start edge SHALL be ignored while the hold counter is non-zero.
REQ-014 In OVER, a start edge with the hold counter at 0 SHALL give OVER -> RUN with the REQ-005 initialisation.
REQ-015 Start edges in RUN SHALL be ignored.
REQ-016 time_out = 1 exactly in OVER; round_active = 1 exactly in RUN. Both are registered, with no combinational input-to-output path.
REQ-017 In OVER, scores and no_of_players SHALL hold their final values for the game-over display.
REQ-018 players_sel changes outside a round start SHALL have no effect.

Reset
REQ-019 rst_n low SHALL immediately set: state IDLE, time_out 0, round_active 0, no_of_players 0, both scores 0, seconds_left ROUND_SECONDS, frame and hold counters 0, edge-detect flops 0.
REQ-020 Reset asserted mid-RUN or mid-OVER SHALL abort the round with no residual state.
REQ-021 After rst_n deassertion, the first start edge SHALL behave per REQ-005.

Structure
REQ-022 State encoding, score width (8) and default timing constants SHALL live in the shared game package/header alongside the VGA bus macros.
REQ-023 A single sub-module, edge_det (registered rising-edge detector, 1-bit), SHALL be instantiated four times; all other logic SHALL be flat.
REQ-024 Outputs SHALL connect directly to the game-over screen overlay inputs TimeOut, NoOfPlayers, Player1Score and Player2Score with no glue logic.

Verification (ROUND_SECONDS=2, FRAMES_PER_SEC=4, HOLD_FRAMES=3)
REQ-025 Reset, then start edge with players_sel=1 -> next cycle: round_active=1, seconds_left=2, no_of_players=1, scores 0.
REQ-026 Feed 8 vsync edges in RUN -> seconds_left 2->1 after tick 4, 1->0 and time_out=1 on the same edge as tick 8.
REQ-027 260 p1_hit edges in RUN -> player1_score=255; with no_of_players=0, 5 p2_hit edges -> player2_score=0.
REQ-028 p1_hit edge coincident with the 8th vsync tick -> score incremented and time_out=1 together.
REQ-029 In OVER, start edge after 2 ticks -> stays OVER; start edge after 3 ticks -> RUN, scores 0, seconds_left=2.
REQ-030 rst_n pulsed low mid-RUN (score 7, seconds_left 1) -> outputs return immediately to REQ-019 values without a clock edge.
